// File: rtl/rom_boot_copier.sv
// rtl/rom_boot_copier.sv - boot-time ROM-to-RAM block copier that holds the core until the copy is done
// Optional running checksum of accepted words: define BOOT_COPY_CHECKSUM_EN.
module rom_boot_copier #(
   parameter int unsigned SIZE_WORDS     = 2**13,
   parameter int unsigned ROM_ADDR_WIDTH = $clog2(4*SIZE_WORDS),
   parameter int unsigned COPY_WORDS     = 256,
   parameter int unsigned SRC_BASE       = 0,
   parameter logic [31:0] DEST_BASE      = 32'h0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
   input  logic [31:0]               rom_rdata,
   output logic                      ram_valid,
   input  logic                      ram_ready,
   output logic [31:0]               ram_addr,
   output logic [31:0]               ram_wdata,
   output logic                      busy,
   output logic                      done,
   output logic                      cpu_hold,
   output logic [31:0]               checksum
);

   localparam int unsigned COUNT = (COPY_WORDS < SIZE_WORDS) ? COPY_WORDS : SIZE_WORDS;
   localparam int unsigned IDX_W = (COPY_WORDS < 1) ? 1 : $clog2(COPY_WORDS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       data_q;
   logic [31:0]       idx_bytes;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         data_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == READ)
            data_q <= rom_rdata;
         if (state == WRITE && ram_ready && idx != LAST_IDX)
            idx <= idx + IDX_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      ram_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = (COUNT == 0) ? DONE : READ;
         end
         READ: begin
            busy      = 1'b1;
            state_nxt = WRITE;
         end
         WRITE: begin
            busy      = 1'b1;
            ram_valid = 1'b1;
            if (ram_ready)
               state_nxt = (idx == LAST_IDX) ? DONE : READ;
         end
         DONE: state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Addresses derive from idx alone, so they stay put during RAM backpressure.
   assign idx_bytes = 32'(idx) << 2;
   assign rom_addr  = ROM_ADDR_WIDTH'(SRC_BASE + idx_bytes);
   assign ram_addr  = DEST_BASE + idx_bytes;
   assign ram_wdata = data_q;
   assign done      = (state == DONE);
   assign cpu_hold  = (state != DONE);

`ifdef BOOT_COPY_CHECKSUM_EN
   logic [31:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst)
         sum_q <= '0;
      else if (ram_valid && ram_ready)
         sum_q <= sum_q + data_q;
   end

   assign checksum = sum_q;
`else
   assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_rom_boot_copier.sv
// tb/tb_rom_boot_copier.sv - randomized self-checking bench for rom_boot_copier
// Expected checksum follows BOOT_COPY_CHECKSUM_EN as defined for the build.
module tb_rom_boot_copier;

   localparam int NI = 4;
   localparam int AW = 6;
   localparam int unsigned CNT   [NI] = '{4, 0, 3, 16};
   localparam int unsigned SRC_W [NI] = '{0, 0, 5, 0};
   localparam logic [31:0] DEST  [NI] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'h0000_1000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0] rst_v, start_v, ready_v;
   logic [NI-1:0] ram_valid_v, busy_v, done_v, hold_v;
   logic [AW-1:0] rom_addr_v  [NI];
   logic [31:0]   rom_rdata_v [NI];
   logic [31:0]   ram_addr_v  [NI];
   logic [31:0]   ram_wdata_v [NI];
   logic [31:0]   checksum_v  [NI];
   logic [31:0]   rom [NI][16];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < NI; g++) begin : g_rom
      assign rom_rdata_v[g] = rom[g][rom_addr_v[g][AW-1:2]];
   end

   rom_boot_copier #(.SIZE_WORDS(16), .COPY_WORDS(4), .SRC_BASE(0), .DEST_BASE(32'h0)) u0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .rom_addr(rom_addr_v[0]),
      .rom_rdata(rom_rdata_v[0]), .ram_valid(ram_valid_v[0]), .ram_ready(ready_v[0]),
      .ram_addr(ram_addr_v[0]), .ram_wdata(ram_wdata_v[0]), .busy(busy_v[0]),
      .done(done_v[0]), .cpu_hold(hold_v[0]), .checksum(checksum_v[0]));

   rom_boot_copier #(.SIZE_WORDS(16), .COPY_WORDS(0), .SRC_BASE(0), .DEST_BASE(32'h0)) u1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .rom_addr(rom_addr_v[1]),
      .rom_rdata(rom_rdata_v[1]), .ram_valid(ram_valid_v[1]), .ram_ready(ready_v[1]),
      .ram_addr(ram_addr_v[1]), .ram_wdata(ram_wdata_v[1]), .busy(busy_v[1]),
      .done(done_v[1]), .cpu_hold(hold_v[1]), .checksum(checksum_v[1]));

   rom_boot_copier #(.SIZE_WORDS(16), .COPY_WORDS(3), .SRC_BASE(20), .DEST_BASE(32'hFFFF_FFF8)) u2 (
      .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .rom_addr(rom_addr_v[2]),
      .rom_rdata(rom_rdata_v[2]), .ram_valid(ram_valid_v[2]), .ram_ready(ready_v[2]),
      .ram_addr(ram_addr_v[2]), .ram_wdata(ram_wdata_v[2]), .busy(busy_v[2]),
      .done(done_v[2]), .cpu_hold(hold_v[2]), .checksum(checksum_v[2]));

   rom_boot_copier #(.SIZE_WORDS(16), .COPY_WORDS(20), .SRC_BASE(0), .DEST_BASE(32'h0000_1000)) u3 (
      .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .rom_addr(rom_addr_v[3]),
      .rom_rdata(rom_rdata_v[3]), .ram_valid(ram_valid_v[3]), .ram_ready(ready_v[3]),
      .ram_addr(ram_addr_v[3]), .ram_wdata(ram_wdata_v[3]), .busy(busy_v[3]),
      .done(done_v[3]), .cpu_hold(hold_v[3]), .checksum(checksum_v[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input int n);
      check("rst_valid",    32'(ram_valid_v[n]), 32'd0);
      check("rst_busy",     32'(busy_v[n]),      32'd0);
      check("rst_done",     32'(done_v[n]),      32'd0);
      check("rst_hold",     32'(hold_v[n]),      32'd1);
      check("rst_checksum", checksum_v[n],       32'd0);
      check("rst_rom_addr", 32'(rom_addr_v[n]),  SRC_W[n] * 4);
      check("rst_ram_addr", ram_addr_v[n],       DEST[n]);
      check("rst_wdata",    ram_wdata_v[n],      32'd0);
   endtask

   task automatic do_reset(input int n);
      rst_v[n] = 1'b1;
      step();
      check_reset(n);
      rst_v[n] = 1'b0;
   endtask

   // mode 0: ready always high; 1: random ready; 2: three stall cycles on word 1
   task automatic run_copy(input int n, input int mode, input int abort_at);
      int          k, cyc, stall, held;
      logic [31:0] sum, exp_ck, pa, pd;
      logic        pv, pr;
      k = 0; stall = 0; held = 0; sum = 0;
      pv = 1'b0; pr = 1'b1; pa = 0; pd = 0;
      ready_v[n] = 1'b1;
      start_v[n] = 1'b1;
      step();
      start_v[n] = 1'b0;
      cyc = 1;
      while (cyc < 400 && !done_v[n]) begin
         case (mode)
            0: ready_v[n] = 1'b1;
            1: ready_v[n] = ($urandom_range(0, 3) != 0);
            default: begin
               if (ram_valid_v[n] && k == 1 && stall < 3) begin
                  ready_v[n] = 1'b0;
                  stall++;
               end else begin
                  ready_v[n] = 1'b1;
               end
            end
         endcase
         check("busy", 32'(busy_v[n]), 32'd1);
         check("hold", 32'(hold_v[n]), 32'd1);
         if (pv && !pr) begin
            check("stall_valid", 32'(ram_valid_v[n]), 32'd1);
            check("stall_addr",  ram_addr_v[n],  pa);
            check("stall_data",  ram_wdata_v[n], pd);
         end
         if (ram_valid_v[n] && k == 1)
            held++;
         if (abort_at >= 0 && k == abort_at && ram_valid_v[n]) begin
            rst_v[n] = 1'b1;
            step();
            check_reset(n);
            rst_v[n] = 1'b0;
            ready_v[n] = 1'b1;
            return;
         end
         if (ram_valid_v[n] && ready_v[n]) begin
            if (k >= int'(CNT[n])) begin
               check("extra_write_idx", k, CNT[n] - 1);
            end else begin
               check("wr_addr", ram_addr_v[n],  DEST[n] + 32'(4 * k));
               check("wr_data", ram_wdata_v[n], rom[n][SRC_W[n] + k]);
               if (mode == 0)
                  check("wr_cycle", cyc, 2 + 2 * k);
               sum = sum + rom[n][SRC_W[n] + k];
               k++;
            end
         end
         pv = ram_valid_v[n];
         pr = ready_v[n];
         pa = ram_addr_v[n];
         pd = ram_wdata_v[n];
         start_v[n] = 1'($urandom_range(0, 1));
         step();
         cyc++;
      end
      start_v[n] = 1'b0;
`ifdef BOOT_COPY_CHECKSUM_EN
      exp_ck = sum;
`else
      exp_ck = 32'h0;
`endif
      check("done",        32'(done_v[n]),      32'd1);
      check("words",       k,                   CNT[n]);
      check("hold_done",   32'(hold_v[n]),      32'd0);
      check("busy_done",   32'(busy_v[n]),      32'd0);
      check("valid_done",  32'(ram_valid_v[n]), 32'd0);
      check("checksum",    checksum_v[n],       exp_ck);
      if (mode == 0)
         check("done_cycle", cyc, 2 * CNT[n] + 1);
      if (mode == 2)
         check("stall_len", held, 4);
   endtask

   initial begin
      rst_v = '1;
      start_v = '0;
      ready_v = '1;
      for (int n = 0; n < NI; n++)
         for (int i = 0; i < 16; i++)
            rom[n][i] = $urandom;
      rom[0][0] = 32'h1111_1111;
      rom[0][1] = 32'h2222_2222;
      rom[0][2] = 32'h3333_3333;
      rom[0][3] = 32'h4444_4444;
      step();
      step();
      for (int n = 0; n < NI; n++)
         check_reset(n);
      rst_v = '0;
      step();

      // four-word copy at full rate, then start pulses in DONE
      run_copy(0, 0, -1);
`ifdef BOOT_COPY_CHECKSUM_EN
      check("checksum_const", checksum_v[0], 32'hAAAA_AAAA);
`endif
      for (int c = 0; c < 4; c++) begin
         start_v[0] = 1'b1;
         step();
         check("sticky_done",     32'(done_v[0]),      32'd1);
         check("sticky_valid",    32'(ram_valid_v[0]), 32'd0);
         check("sticky_rom_addr", 32'(rom_addr_v[0]),  32'd12);
         check("sticky_ram_addr", ram_addr_v[0],       32'd12);
      end
      start_v[0] = 1'b0;

      do_reset(0);
      run_copy(0, 2, -1);

      do_reset(0);
      run_copy(0, 0, 2);
      run_copy(0, 0, -1);

      run_copy(1, 0, -1);
      run_copy(2, 1, -1);
      run_copy(3, 0, -1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++)
            rom[3][i] = $urandom;
         do_reset(3);
         run_copy(3, 1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
